vga_timing_rx: RTL

//  Receive side of video_if: consumes HS/VS/BLANK/RGB from a raster source (on-chip VGA generator or external).

---
 rtl/vga_timing_rx_if.sv | 10 +
 rtl/vga_timing_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx_if.sv
// Raster video bus: HS/VS active low, BLANK high marks an active pixel, RGB valid with BLANK.
interface video_if;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;

    modport master (output hs, vs, blank, rgb);
    modport slave  (input  hs, vs, blank, rgb);
endinterface

// File: rtl/vga_timing_rx.sv
// Raster receiver: recovers pixel coordinates, measures frame geometry and locks
// once two consecutive frames measure identically.
module vga_timing_rx #(
    parameter int HMAX      = 2048,
    parameter int VMAX      = 2048,
    parameter int TIMEOUT   = 1 << 22,
    parameter int EXP_HDISP = 800,
    parameter int EXP_VDISP = 480,
    localparam int XW = $clog2(HMAX),
    localparam int YW = $clog2(VMAX)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    video_if.slave        video_ifs,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [23:0]   pix_rgb,
    output logic          sof,
    output logic          eol,
    output logic          locked,
    output logic          mode_ok,
    output logic [XW-1:0] meas_hact,
    output logic [YW-1:0] meas_vact,
    output logic [XW:0]   meas_htot,
    output logic [7:0]    err_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [XW-1:0] XMAX = XW'(HMAX - 1);
    localparam logic [YW-1:0] YMAX = YW'(VMAX - 1);
    localparam logic [1:0] SEARCH = 2'd0, MEASURE = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3;

    logic          hs_r, vs_r, blank_r, hs_p, vs_p, blank_p;
    logic [23:0]   rgb_r;
    logic          hs_fall, vs_fall, blank_fall;
    logic          sof_pend, x_sat;
    logic [XW:0]   hcnt, f_hact, f_htot, hact_now, hact_f, htot_f;
    logic [YW-1:0] vcnt, vact_f;
    logic          f_htot_vld, line_bad, bad_f, match, timeout;
    logic [1:0]    state;
    logic [TW-1:0] tcnt;

    assign hs_fall    = hs_p & ~hs_r;
    assign vs_fall    = vs_p & ~vs_r;
    assign blank_fall = blank_p & ~blank_r;
    assign x_sat      = (pix_x == XMAX);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            {hs_r, vs_r, blank_r, hs_p, vs_p, blank_p} <= '0;
            rgb_r <= '0;
        end else begin
            hs_r    <= video_ifs.hs;
            vs_r    <= video_ifs.vs;
            blank_r <= video_ifs.blank;
            rgb_r   <= video_ifs.rgb;
            hs_p    <= hs_r;
            vs_p    <= vs_r;
            blank_p <= blank_r;
        end
    end

    // Output stage lags the registered copy by one so the live input serves as eol look-ahead.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            {pix_valid, sof, eol, sof_pend} <= '0;
            pix_x   <= '0;
            pix_y   <= '0;
            pix_rgb <= '0;
        end else begin
            pix_valid <= blank_r;
            pix_rgb   <= rgb_r;
            eol       <= blank_r & ~video_ifs.blank;
            sof       <= blank_r & (sof_pend | vs_fall);
            sof_pend  <= (sof_pend | vs_fall) & ~blank_r;
            if (!blank_r || !pix_valid)
                pix_x <= '0;
            else if (!x_sat)
                pix_x <= pix_x + 1'b1;
            if (vs_fall)
                pix_y <= '0;
            else if (blank_fall && pix_y != YMAX)
                pix_y <= pix_y + 1'b1;
        end
    end

    // Frame view including any line closing in the same cycle as the VS fall.
    always_comb begin
        hact_now = (XW+1)'(pix_x) + 1'b1;
        hact_f   = (blank_fall && vcnt == '0) ? hact_now : f_hact;
        htot_f   = (hs_fall && !f_htot_vld) ? hcnt : f_htot;
        vact_f   = vcnt + YW'(blank_fall && vcnt != YMAX);
        bad_f    = line_bad
                 | (blank_fall && vcnt != '0 && hact_now != f_hact)
                 | (hs_fall && f_htot_vld && hcnt != f_htot)
                 | (blank_r && blank_p && x_sat);
        match    = !bad_f && vact_f != '0 && hact_f == {1'b0, meas_hact}
                 && vact_f == meas_vact && htot_f == meas_htot;
        timeout  = !vs_fall && tcnt == TW'(TIMEOUT - 1);
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hcnt       <= '0;
            vcnt       <= '0;
            f_hact     <= '0;
            f_htot     <= '0;
            f_htot_vld <= 1'b0;
            line_bad   <= 1'b0;
        end else begin
            if (hs_fall)
                hcnt <= (XW+1)'(1);
            else if (~&hcnt)
                hcnt <= hcnt + 1'b1;
            if (vs_fall) begin
                vcnt       <= '0;
                f_htot_vld <= 1'b0;
                line_bad   <= 1'b0;
            end else begin
                line_bad <= bad_f;
                if (blank_fall) begin
                    if (vcnt != YMAX) vcnt <= vcnt + 1'b1;
                    if (vcnt == '0)   f_hact <= hact_now;
                end
                if (hs_fall && !f_htot_vld) begin
                    f_htot     <= hcnt;
                    f_htot_vld <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_cnt   <= '0;
            tcnt      <= '0;
            meas_hact <= '0;
            meas_vact <= '0;
            meas_htot <= '0;
        end else begin
            tcnt <= (vs_fall || timeout) ? '0 : tcnt + 1'b1;
            if (timeout) begin
                state  <= SEARCH;
                locked <= 1'b0;
                if (state == LOCKED && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            end else if (vs_fall) begin
                if (state == SEARCH) begin
                    state <= MEASURE;
                end else if (state == LOCKED && match) begin
                    state <= LOCKED;
                end else if (state == VERIFY && match) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                end else begin
                    if (state == LOCKED && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
                    state     <= VERIFY;
                    locked    <= 1'b0;
                    meas_hact <= hact_f[XW-1:0];
                    meas_vact <= vact_f;
                    meas_htot <= htot_f;
                end
            end
        end
    end

    assign mode_ok = locked && meas_hact == XW'(EXP_HDISP) && meas_vact == YW'(EXP_VDISP);
endmodule
